// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, issues word fetches over a req/ready,
// rvalid handshake and buffers returned words in an in-order queue for decode.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  output logic        fetch_err
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW:0] L_DEPTH = (CW + 1)'(DEPTH);

  // Handshakes: a transfer happens on a rising edge where valid and ready
  // are both high (imem_req/imem_ready, instr_valid/instr_ready); imem_rvalid
  // has no back-pressure and is consumed in the cycle it is high.

  logic [31:0]   r_pc;
  logic [31:0]   r_q_word [DEPTH];
  logic [31:0]   r_q_pc   [DEPTH];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic [CW-1:0] r_outstanding;
  logic [CW-1:0] r_discard;
  logic          r_err;

  logic          w_pop;
  logic          w_accept;
  logic          w_rsp_live;
  logic          w_rsp_stale;
  logic          w_spurious;
  logic          w_push;
  logic [CW:0]   w_used;
  logic [31:0]   w_tag_pc;
  logic          w_unused;

  function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign w_unused    = ^redirect_pc[1:0];
  assign instr_valid = (r_count != '0) && !redirect_valid;
  assign w_pop       = instr_valid && instr_ready;

  // A head popped this cycle frees its slot immediately, which is what lets
  // a 1-cycle memory sustain one instruction per cycle at DEPTH = 2.
  assign w_used   = {1'b0, r_count} + {1'b0, r_outstanding} - {{CW{1'b0}}, w_pop};
  assign imem_req = !rst && !redirect_valid && (w_used < L_DEPTH);
  assign w_accept = imem_req && imem_ready;

  assign w_rsp_stale = imem_rvalid && (r_discard != '0);
  assign w_rsp_live  = imem_rvalid && (r_discard == '0) && (r_outstanding != '0);
  assign w_spurious  = imem_rvalid && (r_discard == '0) && (r_outstanding == '0);
  assign w_push      = w_rsp_live && !redirect_valid;

  // Live fetches are contiguous since the last redirect, so the oldest one
  // sits exactly r_outstanding words behind the fetch PC.
  assign w_tag_pc = r_pc - 32'({r_outstanding, 2'b00});

  assign imem_addr = r_pc;
  assign instr     = (r_count != '0) ? r_q_word[r_rd_ptr] : '0;
  assign instr_pc  = (r_count != '0) ? r_q_pc[r_rd_ptr]   : '0;
  assign fetch_err = r_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc          <= RESET_PC;
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
      r_count       <= '0;
      r_outstanding <= '0;
      r_discard     <= '0;
      r_err         <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_q_word[i] <= '0;
        r_q_pc[i]   <= '0;
      end
    end else begin
      if (w_spurious) r_err <= 1'b1;
      if (redirect_valid) begin
        // Everything still in flight becomes stale; a response arriving now
        // is stale by definition and is charged against that total.
        r_pc          <= {redirect_pc[31:2], 2'b00};
        r_rd_ptr      <= '0;
        r_wr_ptr      <= '0;
        r_count       <= '0;
        r_outstanding <= '0;
        r_discard     <= r_discard + r_outstanding - CW'(imem_rvalid && !w_spurious);
      end else begin
        if (w_accept) r_pc <= r_pc + 32'd4;
        r_outstanding <= r_outstanding + CW'(w_accept) - CW'(w_rsp_live);
        if (w_rsp_stale) r_discard <= r_discard - CW'(1);
        if (w_push) begin
          r_q_word[r_wr_ptr] <= imem_rdata;
          r_q_pc[r_wr_ptr]   <= w_tag_pc;
          r_wr_ptr           <= f_inc(r_wr_ptr);
        end
        if (w_pop) r_rd_ptr <= f_inc(r_rd_ptr);
        r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: behavioural memory with programmable latency, an
// in-order scoreboard on the decode side, and a table of redirect vectors.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata  = '0;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        fetch_err;

  typedef struct {
    logic [31:0] rpc;
    logic [31:0] exp_addr;
    logic [31:0] exp_pc1;
    int          lat;
    bit          decoy;
  } vec_t;

  typedef struct {
    int          due;
    logic [31:0] addr;
  } mreq_t;

  vec_t        vecs [4];
  mreq_t       mem_q [$];
  logic [31:0] exp_q [$];
  int          cyc = 0;
  int          lat = 1;
  int          spur_cnt = 0;
  int          spur_done = 0;
  int          n_pass = 0;
  int          n_total = 0;
  int          n_pops = 0;
  bit          sb_on = 1'b0;

  instr_fetch #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_ready    (instr_ready),
    .fetch_err      (fetch_err)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    else n_pass++;
  endtask

  // ---------------- memory model: in-order, fixed latency per request ----------------
  always @(negedge clk) begin
    mreq_t m;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    if (rst) mem_q.delete();
    else if (spur_cnt != spur_done) begin
      spur_done++;
      imem_rvalid = 1'b1;
      imem_rdata  = 32'hDEAD_BEEF;
    end else if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_q[0].addr ^ 32'hA5A5_0000;
      void'(mem_q.pop_front());
    end
    #2;
    if (!rst && imem_req && imem_ready) begin
      m.due  = cyc + lat;
      m.addr = imem_addr;
      mem_q.push_back(m);
    end
  end

  // ---------------- scoreboard on consumed instructions ----------------
  always @(negedge clk) begin
    logic [31:0] e;
    #3;
    if (sb_on && instr_valid && instr_ready) begin
      n_pops++;
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL sb_extra: got pc %h expected no instruction", instr_pc);
      end else begin
        e = exp_q.pop_front();
        check("sb_pc", instr_pc, e);
        check("sb_instr", instr, e ^ 32'hA5A5_0000);
      end
    end
  end

  // ---------------- driver helpers ----------------
  task automatic wait_valid(output int c);
    c = -1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      #4;
      if (instr_valid) begin
        c = cyc;
        break;
      end
    end
    if (c < 0) begin
      n_total++;
      $display("FAIL valid_timeout: got no instr_valid expected one within 30 cycles");
    end
  endtask

  task automatic drain_and_stop();
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0) break;
    end
    if (exp_q.size() != 0) begin
      n_total++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
    end
    instr_ready = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int c0;
    int c;
    int p0;
    int r_cyc;

    vecs[0] = '{32'h0000_0103, 32'h0000_0100, 32'h0000_0104, 3, 1'b1};
    vecs[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFC, 32'h0000_0000, 1, 1'b0};
    vecs[2] = '{32'h0000_2002, 32'h0000_2000, 32'h0000_2004, 2, 1'b0};
    vecs[3] = '{32'h8000_0001, 32'h8000_0000, 32'h8000_0004, 1, 1'b0};

    rst = 1'b1; imem_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    instr_ready = 1'b0;
    repeat (3) @(negedge clk);
    #4;
    check("rst_req", imem_req, 0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_valid", instr_valid, 0);
    check("rst_instr", instr, 32'h0);
    check("rst_instr_pc", instr_pc, 32'h0);
    check("rst_err", fetch_err, 0);

    // streaming with 1-cycle memory
    @(negedge clk);
    rst = 1'b0; instr_ready = 1'b1; sb_on = 1'b1;
    for (int k = 0; k < 64; k++) exp_q.push_back(32'(4 * k));
    c0 = cyc;
    #4;
    check("first_req", imem_req, 1);
    check("first_addr", imem_addr, 32'h0);
    wait_valid(c);
    check("first_valid_cycle", 32'(c), 32'(c0 + 2));
    check("first_instr_pc", instr_pc, 32'h0);
    check("first_instr", instr, 32'hA5A5_0000);
    p0 = n_pops;
    repeat (12) @(negedge clk);
    #4;
    check("throughput", 32'(n_pops - p0), 32'd12);

    // decode stall: credit stops requests, nothing is lost
    @(negedge clk);
    instr_ready = 1'b0;
    #4;
    check("stall_req_drop", imem_req, 0);
    repeat (9) @(negedge clk);
    #4;
    check("stall_req_held", imem_req, 0);
    check("stall_valid", instr_valid, 1);
    check("stall_head", instr_pc, exp_q[0]);
    @(negedge clk);
    instr_ready = 1'b1;
    repeat (6) @(negedge clk);

    // redirect colliding with a response and a ready consumer
    #1;
    check("redir_rvalid_setup", imem_rvalid, 1);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0602;
    exp_q.delete();
    r_cyc = cyc;
    #3;
    check("redir_valid_low", instr_valid, 0);
    check("redir_req_low", imem_req, 0);
    @(negedge clk);
    redirect_valid = 1'b0;
    for (int k = 0; k < 16; k++) exp_q.push_back(32'h600 + 32'(4 * k));
    #4;
    check("redir_empty_valid", instr_valid, 0);
    check("redir_empty_instr", instr, 32'h0);
    check("redir_empty_pc", instr_pc, 32'h0);
    check("redir_new_addr", imem_addr, 32'h600);
    wait_valid(c);
    check("redir_valid_cycle", 32'(c), 32'(r_cyc + 3));

    // memory back-pressure: address must hold while not accepted
    @(negedge clk);
    imem_ready = 1'b0;
    #4;
    check("hold_addr0", imem_addr, 32'h60C);
    check("hold_req0", imem_req, 1);
    @(negedge clk);
    #4;
    check("hold_addr1", imem_addr, 32'h60C);
    check("hold_req1", imem_req, 1);
    @(negedge clk);
    imem_ready = 1'b1; lat = 3;
    #4;
    check("hold_addr2", imem_addr, 32'h60C);
    repeat (4) @(negedge clk);

    // redirect vectors
    for (int v = 0; v < 4; v++) begin
      @(negedge clk);
      lat = vecs[v].lat;
      instr_ready = 1'b1;
      if (vecs[v].decoy) begin
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0400;
        exp_q.delete();
        #4;
        check("decoy_req", imem_req, 0);
        @(negedge clk);
      end
      redirect_valid = 1'b1; redirect_pc = vecs[v].rpc;
      exp_q.delete();
      r_cyc = cyc;
      #4;
      check("vec_redir_req", imem_req, 0);
      check("vec_redir_valid", instr_valid, 0);
      @(negedge clk);
      redirect_valid = 1'b0;
      exp_q.push_back(vecs[v].exp_addr);
      exp_q.push_back(vecs[v].exp_pc1);
      for (int k = 1; k <= 4; k++) exp_q.push_back(vecs[v].exp_pc1 + 32'(4 * k));
      #4;
      check("vec_addr", imem_addr, vecs[v].exp_addr);
      check("vec_req", imem_req, 1);
      wait_valid(c);
      check("vec_valid_cycle", 32'(c), 32'(r_cyc + 2 + vecs[v].lat));
      drain_and_stop();
    end

    // spurious response with nothing outstanding
    @(negedge clk);
    #4;
    check("spur_pre_head", instr_pc, 32'h8000_0018);
    check("spur_pre_req", imem_req, 0);
    spur_cnt++;
    @(negedge clk);
    @(negedge clk);
    #4;
    check("spur_err", fetch_err, 1);
    check("spur_head_pc", instr_pc, 32'h8000_0018);
    check("spur_head_instr", instr, 32'h25A5_0018);
    check("spur_head_valid", instr_valid, 1);
    sb_on = 1'b0;
    @(negedge clk);
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
    #4;
    check("spur_next_head", instr_pc, 32'h8000_001C);
    repeat (4) @(negedge clk);
    #4;
    check("err_sticky", fetch_err, 1);

    // asynchronous reset mid-operation
    @(negedge clk);
    #1 rst = 1'b1;
    #3;
    check("arst_err", fetch_err, 0);
    check("arst_valid", instr_valid, 0);
    check("arst_req", imem_req, 0);
    check("arst_addr", imem_addr, 32'h0);
    check("arst_instr", instr, 32'h0);
    check("arst_instr_pc", instr_pc, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #4;
    check("rel_req", imem_req, 1);
    check("rel_addr", imem_addr, 32'h0);
    repeat (4) @(negedge clk);
    #4;
    check("rel_err", fetch_err, 0);
    check("rel_head_pc", instr_pc, 32'h0);
    check("rel_head_instr", instr, 32'hA5A5_0000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
